mux_4to1: RTL and testbench



---
 rtl/alu_pkg.sv | 15 +
 rtl/mux_2to1_cell.sv | 19 +
 rtl/mux_4to1.sv | 62 ++++++
 tb/tb_mux_4to1.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation-select encoding used by the result mux.
package alu_pkg;

  // Select encoding of the 4:1 result mux
  localparam logic [1:0] SEL_A = 2'b00;
  localparam logic [1:0] SEL_B = 2'b01;
  localparam logic [1:0] SEL_C = 2'b10;
  localparam logic [1:0] SEL_D = 2'b11;

  // ALU operation aliases: the mux inputs carry AND, OR and ADD results
  localparam logic [1:0] OP_AND = SEL_A;
  localparam logic [1:0] OP_OR  = SEL_B;
  localparam logic [1:0] OP_ADD = SEL_C;

endpackage

// File: rtl/mux_2to1_cell.sv
// Single-bit 2:1 selector in explicit AND/OR/NOT form; building block of the
// two-level 4:1 tree in mux_4to1.
module mux_2to1_cell (
  input  logic s,
  input  logic i0,
  input  logic i1,
  output logic y
);

  logic s_n_s;
  logic pick0_s;
  logic pick1_s;

  assign s_n_s   = ~s;
  assign pick0_s = s_n_s & i0;
  assign pick1_s = s & i1;
  assign y       = pick0_s | pick1_s;

endmodule

// File: rtl/mux_4to1.sv
// Parameterised 4:1 selector with a combinational output and a one-cycle
// registered copy qualified by out_valid_q. Final stage of the ALU.
module mux_4to1
  import alu_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       sel,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  input  logic             in_valid,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] out_q,
  output logic             out_valid_q
);

  // First-level results: sel[0] chooses a/b and c/d independently per bit
  logic [WIDTH-1:0] lo_s;
  logic [WIDTH-1:0] hi_s;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    mux_2to1_cell u_lo (
      .s  (sel[0]),
      .i0 (a[i]),
      .i1 (b[i]),
      .y  (lo_s[i])
    );

    mux_2to1_cell u_hi (
      .s  (sel[0]),
      .i0 (c[i]),
      .i1 (d[i]),
      .y  (hi_s[i])
    );

    // Second level: sel[1] chooses between the a/b and c/d results
    mux_2to1_cell u_top (
      .s  (sel[1]),
      .i0 (lo_s[i]),
      .i1 (hi_s[i]),
      .y  (out[i])
    );
  end

  // Capture the selected word when in_valid is high; valid flag tracks in_valid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q       <= {WIDTH{1'b0}};
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= in_valid;
      if (in_valid) begin
        out_q <= out;
      end
    end
  end

endmodule

// File: tb/tb_mux_4to1.sv
// Scoreboard bench for mux_4to1: WIDTH=1 exhaustive check plus a WIDTH=32
// instance driven with directed and random stimulus.
module tb_mux_4to1;
  import alu_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [1:0]  sel;
  logic [31:0] a, b, c, d;
  logic        in_valid;
  logic [31:0] out, out_q;
  logic        out_valid_q;

  logic [1:0]  sel1;
  logic        a1, b1, c1, d1, in_valid1;
  logic        out1, out_q1, out_valid_q1;

  mux_4to1 #(.WIDTH(32)) u_dut (
    .clk(clk), .rst_n(rst_n), .sel(sel), .a(a), .b(b), .c(c), .d(d),
    .in_valid(in_valid), .out(out), .out_q(out_q), .out_valid_q(out_valid_q)
  );

  mux_4to1 #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .sel(sel1), .a(a1), .b(b1), .c(c1), .d(d1),
    .in_valid(in_valid1), .out(out1), .out_q(out_q1), .out_valid_q(out_valid_q1)
  );

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [31:0] q;
    logic        v;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] mq;
  logic        mv;

  // Reference: the select value indexes the list of inputs
  function automatic logic [31:0] ref_mux(input logic [1:0] s, input logic [31:0] ia,
                                          input logic [31:0] ib, input logic [31:0] ic,
                                          input logic [31:0] id);
    logic [31:0] pick [4];
    pick[0] = ia;
    pick[1] = ib;
    pick[2] = ic;
    pick[3] = id;
    return pick[s];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual %h required %h", name, act, exp);
    end
  endtask

  // Apply one cycle of stimulus, check the combinational output, and queue the
  // register state expected after the following rising edge.
  task automatic drive(input logic [1:0] s, input logic [31:0] ia, input logic [31:0] ib,
                       input logic [31:0] ic, input logic [31:0] id, input logic v);
    logic [31:0] r;
    @(negedge clk);
    sel = s; a = ia; b = ib; c = ic; d = id; in_valid = v;
    #1;
    r = ref_mux(s, ia, ib, ic, id);
    check("comb_out", out, r);
    if (!rst_n) begin
      mq = 32'd0;
      mv = 1'b0;
    end else if (v) begin
      mq = r;
      mv = 1'b1;
    end else begin
      mv = 1'b0;
    end
    sb.push_back('{mq, mv});
  endtask

  // Assert reset between edges, check the immediate clear, release at negedge
  task automatic pulse_reset(input logic [1:0] s);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_out_q", out_q, 32'd0);
    check("rst_out_valid_q", {31'd0, out_valid_q}, 32'd0);
    sel = s;
    #1;
    check("rst_comb_out", out, ref_mux(s, a, b, c, d));
    in_valid = 1'b0;
    mq = 32'd0;
    mv = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor: after every rising edge, pop and compare any queued expectation
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("out_q", out_q, e.q);
        check("out_valid_q", {31'd0, out_valid_q}, {31'd0, e.v});
      end
    end
  end

  // Watchdog so the run always ends
  initial begin
    #200000;
    fails++;
    $display("FAIL watchdog: actual timeout required finish");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Main stimulus sequence
  initial begin
    logic exp1;
    logic [5:0] k6;
    rst_n = 1'b0;
    sel = 2'b00; a = 32'd0; b = 32'd0; c = 32'd0; d = 32'd0; in_valid = 1'b0;
    sel1 = 2'b00; a1 = 1'b0; b1 = 1'b0; c1 = 1'b0; d1 = 1'b0; in_valid1 = 1'b0;
    mq = 32'd0;
    mv = 1'b0;
    #2;
    check("reset_out_q", out_q, 32'd0);
    check("reset_out_valid_q", {31'd0, out_valid_q}, 32'd0);
    check("reset_out_q1", {30'd0, out_valid_q1, out_q1}, 32'd0);

    // WIDTH=1 exhaustive against the per-bit equation
    for (int k = 0; k < 64; k++) begin
      k6 = k[5:0];
      {sel1, a1, b1, c1, d1} = k6;
      #1;
      exp1 = (~sel1[1] & ~sel1[0] & a1) | (~sel1[1] & sel1[0] & b1) |
             (sel1[1] & ~sel1[0] & c1) | (sel1[1] & sel1[0] & d1);
      check("w1_out", {31'd0, out1}, {31'd0, exp1});
    end

    @(negedge clk);
    rst_n = 1'b1;

    // WIDTH=1 registered capture of the prior combinational result
    @(negedge clk);
    sel1 = 2'b10; a1 = 1'b0; b1 = 1'b0; c1 = 1'b1; d1 = 1'b0; in_valid1 = 1'b1;
    @(posedge clk);
    #1;
    check("w1_out_q", {31'd0, out_q1}, 32'd1);
    check("w1_out_valid_q", {31'd0, out_valid_q1}, 32'd1);
    in_valid1 = 1'b0;

    // Directed ALU-style pattern, combinational only
    drive(SEL_A, 32'h00000000, 32'hFFFFFFFF, 32'h4B4B4B4A, 32'h00000000, 1'b0);
    drive(SEL_B, 32'h00000000, 32'hFFFFFFFF, 32'h4B4B4B4A, 32'h00000000, 1'b0);
    drive(SEL_C, 32'h00000000, 32'hFFFFFFFF, 32'h4B4B4B4A, 32'h00000000, 1'b0);
    drive(SEL_D, 32'h00000000, 32'hFFFFFFFF, 32'h4B4B4B4A, 32'h00000000, 1'b0);

    // Registered capture then hold
    drive(OP_OR, 32'h00000000, 32'hFFFFFFFF, 32'h4B4B4B4A, 32'h00000000, 1'b1);
    drive(OP_AND, 32'h00000000, 32'hFFFFFFFF, 32'h4B4B4B4A, 32'h00000000, 1'b0);

    // Async reset with out_q holding all-ones
    drive(OP_OR, 32'h00000000, 32'hFFFFFFFF, 32'h4B4B4B4A, 32'h00000000, 1'b1);
    pulse_reset(SEL_C);

    // Streaming: one capture per edge across all four selects
    for (int s = 0; s < 4; s++) begin
      drive(2'(s), 32'h00000000, 32'hFFFFFFFF, 32'h4B4B4B4A, 32'h00000000, 1'b1);
    end
    drive(SEL_A, 32'h00000000, 32'hFFFFFFFF, 32'h4B4B4B4A, 32'h00000000, 1'b0);

    // Random traffic with a mid-stream reset
    for (int n = 0; n < 80; n++) begin
      drive(2'($urandom_range(0, 3)), $urandom, $urandom, $urandom, $urandom,
            1'($urandom_range(0, 1)));
      if (n == 40) begin
        drive(2'($urandom_range(0, 3)), $urandom, $urandom, $urandom, $urandom, 1'b1);
        pulse_reset(2'($urandom_range(0, 3)));
      end
    end

    repeat (3) @(posedge clk);
    #2;
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
